// File: rtl/clk_div_monitor.sv
// Frequency/lock monitor for a divided clock: measures the clkin-cycle period
// between div_clk rising edges and reports lock, sticky period error and stuck clock.
module clk_div_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             div_clk,
  input  logic             enable,
  input  logic [CNT_W-1:0] expected_period,
  input  logic             clr_err,
  output logic             locked,
  output logic             period_err,
  output logic             stuck,
  output logic             lock_lost,
  output logic [CNT_W-1:0] last_period,
  output logic [1:0]       dbg_state_o,
  output logic [CNT_W-1:0] dbg_period_cnt_o,
  output logic [3:0]       dbg_good_cnt_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    CHECK     = 2'd2,
    LOCKED    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic [CNT_W-1:0]     period_cnt_q, period_cnt_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]     last_period_q, last_period_d;
  logic                 locked_q, locked_d;
  logic                 period_err_q, period_err_d;
  logic                 stuck_q, stuck_d;
  logic                 lock_lost_q, lock_lost_d;

  logic                 rise;
  logic                 in_tol;
  logic                 timeout_hit;
  logic [CNT_W-1:0]     cnt_inc;
  logic [3:0]           good_inc;
  logic [CNT_W:0]       p_ext, e_ext, diff;
  logic                 err_set, stuck_set;

  // div_clk is asynchronous: synchronize, then keep one history flop for rise detect
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Distance computed one bit wider so the subtraction never wraps
  always_comb begin
    p_ext  = {1'b0, period_cnt_q};
    e_ext  = {1'b0, expected_period};
    diff   = (p_ext >= e_ext) ? (p_ext - e_ext) : (e_ext - p_ext);
    in_tol = (diff <= TOL_C);
  end

  assign cnt_inc     = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
  assign good_inc    = good_cnt_q + 4'd1;
  assign timeout_hit = (period_cnt_q == TIMEOUT_C);

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    good_cnt_d    = good_cnt_q;
    last_period_d = last_period_q;
    err_set       = 1'b0;
    stuck_set     = 1'b0;
    lock_lost_d   = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      good_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = WAIT_EDGE;
          period_cnt_d = '0;
        end
        WAIT_EDGE: begin
          // The arming edge only starts a measurement; it is never evaluated
          if (rise) begin
            state_d      = CHECK;
            period_cnt_d = CNT_ONE;
            good_cnt_d   = '0;
          end else begin
            period_cnt_d = cnt_inc;
            if (timeout_hit) begin
              stuck_set  = 1'b1;
              good_cnt_d = '0;
            end
          end
        end
        CHECK: begin
          if (rise) begin
            last_period_d = period_cnt_q;
            period_cnt_d  = CNT_ONE;
            if (in_tol) begin
              good_cnt_d = good_inc;
              if (good_inc == LOCK_C) state_d = LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end else begin
            period_cnt_d = cnt_inc;
            if (timeout_hit) begin
              stuck_set  = 1'b1;
              state_d    = WAIT_EDGE;
              good_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (rise) begin
            last_period_d = period_cnt_q;
            period_cnt_d  = CNT_ONE;
            if (!in_tol) begin
              state_d     = CHECK;
              good_cnt_d  = '0;
              err_set     = 1'b1;
              lock_lost_d = 1'b1;
            end
          end else begin
            period_cnt_d = cnt_inc;
            if (timeout_hit) begin
              stuck_set   = 1'b1;
              state_d     = WAIT_EDGE;
              good_cnt_d  = '0;
              lock_lost_d = 1'b1;
            end
          end
        end
        default: begin
          state_d      = IDLE;
          period_cnt_d = '0;
          good_cnt_d   = '0;
        end
      endcase
    end

    // Set has priority over a coincident clear
    period_err_d = err_set | (period_err_q & ~clr_err);
    stuck_d      = stuck_set | (stuck_q & ~clr_err);
    locked_d     = (state_d == LOCKED);
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      period_cnt_q  <= '0;
      good_cnt_q    <= '0;
      last_period_q <= '0;
      locked_q      <= 1'b0;
      period_err_q  <= 1'b0;
      stuck_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      good_cnt_q    <= good_cnt_d;
      last_period_q <= last_period_d;
      locked_q      <= locked_d;
      period_err_q  <= period_err_d;
      stuck_q       <= stuck_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign locked           = locked_q;
  assign period_err       = period_err_q;
  assign stuck            = stuck_q;
  assign lock_lost        = lock_lost_q;
  assign last_period      = last_period_q;
  assign dbg_state_o      = state_q;
  assign dbg_period_cnt_o = period_cnt_q;
  assign dbg_good_cnt_o   = good_cnt_q;

endmodule
